// File: rtl/op_display_scanner_if.sv
// Operation-readout bus between the calculator control FSM (master) and the
// display scanner (slave): code load strobe in, scan pins and status out.
interface op_display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [2:0]            operation;
  logic                  op_load;
  logic                  op_pending;
  logic                  frame_tick;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0]            seg_n;

  modport master (
    output operation, op_load,
    input  op_pending, frame_tick, an_n, seg_n
  );

  modport slave (
    input  operation, op_load,
    output op_pending, frame_tick, an_n, seg_n
  );
endinterface

// File: rtl/op_display_scanner.sv
// Time-multiplexed seven-segment driver for the operation readout; op changes commit at frame wrap.
// Optional macro OPDISP_BLINK_EN: invalid codes show a blinking "Err" instead of blank.
module op_display_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  op_display_scanner_if.slave  bus
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W  = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_U     = 7'h41;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_M     = 7'h48;
  localparam logic [6:0] GLYPH_L     = 7'h47;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
`ifdef OPDISP_BLINK_EN
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_R     = 7'h2F;
`endif

  // Right-justified three-letter text: digit 2 is the leading letter.
  function automatic logic [6:0] glyph_for(input logic [2:0] code, input logic [DIG_W-1:0] digit);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (code)
      OP_ADD: begin
        case (digit)
          DIG_W'(0), DIG_W'(1): g = GLYPH_D;
          DIG_W'(2):            g = GLYPH_A;
          default:              g = GLYPH_BLANK;
        endcase
      end
      OP_SUB: begin
        case (digit)
          DIG_W'(0): g = GLYPH_B;
          DIG_W'(1): g = GLYPH_U;
          DIG_W'(2): g = GLYPH_S;
          default:   g = GLYPH_BLANK;
        endcase
      end
      OP_MUL: begin
        case (digit)
          DIG_W'(0): g = GLYPH_L;
          DIG_W'(1): g = GLYPH_U;
          DIG_W'(2): g = GLYPH_M;
          default:   g = GLYPH_BLANK;
        endcase
      end
      default: begin
`ifdef OPDISP_BLINK_EN
        case (digit)
          DIG_W'(0), DIG_W'(1): g = GLYPH_R;
          DIG_W'(2):            g = GLYPH_E;
          default:              g = GLYPH_BLANK;
        endcase
`else
        g = GLYPH_BLANK;
`endif
      end
    endcase
    return g;
  endfunction

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [2:0]            active_q, active_d;
  logic [2:0]            pending_q, pending_d;
  logic                  op_pending_q, op_pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  slot_wrap;
  logic                  frame_wrap;

`ifdef OPDISP_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             hidden_q, hidden_d;
  logic             commit;
  logic             active_valid;
`endif

  // Scan sequencing, load/commit of the op code and aligned pin decode.
  always_comb begin
    slot_d       = slot_q;
    digit_d      = digit_q;
    active_d     = active_q;
    pending_d    = pending_q;
    op_pending_d = op_pending_q;
    frame_tick_d = 1'b0;

    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (digit_q == DIG_LAST);

    slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
    if (slot_wrap) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
    end

    if (bus.op_load) begin
      pending_d    = bus.operation;
      op_pending_d = 1'b1;
    end

    // A load on the wrap edge bypasses the pending register and shows this frame.
    if (frame_wrap) begin
      active_d     = bus.op_load ? bus.operation : pending_q;
      op_pending_d = 1'b0;
      frame_tick_d = 1'b1;
    end

    an_n_d  = ~(NUM_DIGITS'(1) << digit_d);
    seg_n_d = glyph_for(active_d, digit_d);

`ifdef OPDISP_BLINK_EN
    blink_cnt_d  = blink_cnt_q;
    hidden_d     = hidden_q;
    commit       = frame_wrap && (op_pending_q || bus.op_load);
    active_valid = (active_d == OP_ADD) || (active_d == OP_SUB) || (active_d == OP_MUL);

    // Every real commit restarts the blink cycle in its visible half.
    if (commit) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    if (hidden_d && !active_valid) begin
      seg_n_d = GLYPH_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      digit_q      <= '0;
      active_q     <= 3'b000;
      pending_q    <= 3'b000;
      op_pending_q <= 1'b0;
      frame_tick_q <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= GLYPH_BLANK;
    end else begin
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      op_pending_q <= op_pending_d;
      frame_tick_q <= frame_tick_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
    end
  end

`ifdef OPDISP_BLINK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
    end
  end
`endif

  assign bus.op_pending = op_pending_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;

endmodule

// File: tb/tb_op_display_scanner.sv
// Scoreboard bench for op_display_scanner: a cycle-count reference model queues expected pins,
// a negedge monitor pops and compares. Honours OPDISP_BLINK_EN if defined.
module tb_op_display_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = ND * SD;

  logic clk = 1'b0;
  logic reset = 1'b0;

  op_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  op_display_scanner #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       pend;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: edges since reset release, codes, frames since last real commit.
  int         edges;
  logic [2:0] m_active;
  logic [2:0] m_pending;
  bit         m_pend;
  int         frames_since;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int d, input logic [2:0] code);
    logic [6:0] txt [3];
    txt = '{7'h7F, 7'h7F, 7'h7F};
    case (code)
      3'b001:  txt = '{7'h21, 7'h21, 7'h08};
      3'b010:  txt = '{7'h03, 7'h41, 7'h12};
      3'b100:  txt = '{7'h47, 7'h41, 7'h48};
`ifdef OPDISP_BLINK_EN
      default: txt = '{7'h2F, 7'h2F, 7'h06};
`else
      default: txt = '{7'h7F, 7'h7F, 7'h7F};
`endif
    endcase
    if (d >= 3) return 7'h7F;
    return txt[d];
  endfunction

  task automatic model_reset();
    edges        = 0;
    m_active     = 3'b000;
    m_pending    = 3'b000;
    m_pend       = 1'b0;
    frames_since = 0;
  endtask

  task automatic model_edge(input bit load, input logic [2:0] op);
    exp_t e;
    bit   tick;
    bit   committed;
    int   d;
    tick = 1'b0;
    if ((edges % FRAME) == FRAME - 1) begin
      committed = load || m_pend;
      if (load) m_pending = op;
      m_active     = m_pending;
      m_pend       = 1'b0;
      tick         = 1'b1;
      frames_since = committed ? 0 : frames_since + 1;
    end else if (load) begin
      m_pending = op;
      m_pend    = 1'b1;
    end
    edges++;
    d      = (edges / SD) % ND;
    e.an   = ~(4'(1) << d);
    e.seg  = ref_glyph(d, m_active);
`ifdef OPDISP_BLINK_EN
    if (((frames_since / BF) % 2) == 1 &&
        !(m_active == 3'b001 || m_active == 3'b010 || m_active == 3'b100))
      e.seg = 7'h7F;
`endif
    e.pend = m_pend;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge sample them, queue the model's view of the result.
  task automatic step(input bit load, input logic [2:0] op);
    bus.op_load   = load;
    bus.operation = op;
    @(posedge clk);
    #1;
    model_edge(load, op);
    bus.op_load   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000);
  endtask

  task automatic to_commit_edge();
    while ((edges % FRAME) != FRAME - 1) step(1'b0, 3'b000);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, " an_n"},       16'(bus.an_n),       16'h000F);
    check({tag, " seg_n"},      16'(bus.seg_n),      16'h007F);
    check({tag, " op_pending"}, 16'(bus.op_pending), 16'h0000);
    check({tag, " frame_tick"}, 16'(bus.frame_tick), 16'h0000);
  endtask

  // Asserted mid-cycle once the scoreboard has drained; released mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_pins("reset async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_reset_pins("reset held");
    end
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("an_n",       16'(bus.an_n),       16'(e.an));
      check("seg_n",      16'(bus.seg_n),      16'(e.seg));
      check("op_pending", 16'(bus.op_pending), 16'(e.pend));
      check("frame_tick", 16'(bus.frame_tick), 16'(e.tick));
    end
  end

  initial begin
    bus.op_load   = 1'b0;
    bus.operation = 3'b000;
    model_reset();
    #2;
    do_reset();

    // Blank scan after release, then a reset in the middle of a frame.
    idle(FRAME + 6);
    do_reset();
    idle(FRAME);

    // Add loaded mid-frame commits at the wrap.
    to_commit_edge();
    idle(5);
    step(1'b1, 3'b001);
    idle(2 * FRAME);

    // Two loads in one frame: the last wins.
    step(1'b1, 3'b010);
    idle(3);
    step(1'b1, 3'b100);
    idle(2 * FRAME);

    // Load exactly on the commit edge.
    step(1'b1, 3'b010);
    to_commit_edge();
    step(1'b1, 3'b100);
    idle(FRAME + 3);

    // Invalid code, then back to a valid one.
    step(1'b1, 3'b111);
    idle(5 * FRAME);
    step(1'b1, 3'b001);
    idle(3 * FRAME);

    // Reset with a load pending discards it.
    step(1'b1, 3'b010);
    idle(2);
    do_reset();
    idle(2 * FRAME);

    // Randomized loads with occasional resets.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 5) == 0) begin
        step(1'b1, 3'($urandom_range(0, 7)));
      end else begin
        step(1'b0, 3'($urandom_range(0, 7)));
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
